// File: rtl/uart_tx_engine.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_tx_engine
//   UART transmitter with a built-in 1x bit-period timer. It accepts one word
//   per valid/ready handshake and serialises it onto the tx line as:
//   start(0), DATA_BITS data bits LSB-first, optional parity, STOP_BITS stop(1).
//   The baud code, parity settings and data word are latched at accept time,
//   so changes to these inputs never disturb a frame in flight.
//
// Parameters
//   CLOCK_FREQ  system clock in Hz; divisor = (CLOCK_FREQ + baud/2) / baud
//   DATA_BITS   data bits per frame (5..8)
//   STOP_BITS   stop bits per frame (1 or 2)
//
// Ports
//   clock       system clock, rising edge
//   reset_n     asynchronous active-low reset
//   baud_rate   00=2400 01=4800 10=9600 11=19200
//   parity_en   1 = append a parity bit after the data
//   parity_odd  1 = odd parity, 0 = even (only used with parity_en)
//   tx_data     word to send
//   tx_valid    tx_data is valid
//   tx_ready    engine idle and able to accept (combinational)
//   tx          serial line, registered, idles high
//   tx_busy     frame in progress (registered)
//   tx_done     one-cycle pulse at the end of the final stop bit
// ---------------------------------------------------------------------------
module uart_tx_engine #(
    parameter int unsigned CLOCK_FREQ = 100_000_000,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [1:0]           baud_rate,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    // Rounded divisors; each must fit the 16-bit bit-period counter.
    localparam int unsigned DIV_2400  = (CLOCK_FREQ + 1200) / 2400;
    localparam int unsigned DIV_4800  = (CLOCK_FREQ + 2400) / 4800;
    localparam int unsigned DIV_9600  = (CLOCK_FREQ + 4800) / 9600;
    localparam int unsigned DIV_19200 = (CLOCK_FREQ + 9600) / 19200;

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state, state_next;
    logic [15:0]            div_q, div_next;      // latched bit period
    logic [15:0]            cnt_q, cnt_next;      // clocks into current bit
    logic [2:0]             idx_q, idx_next;      // data / stop bit index
    logic [DATA_BITS-1:0]   shift_q, shift_next;  // bit 0 is the one on the line
    logic                   par_en_q, par_en_next;
    logic                   par_bit_q, par_bit_next;
    logic                   tx_next, busy_next, done_next;
    logic                   bit_end;

    function automatic logic [15:0] baud_div(input logic [1:0] code);
        logic [15:0] d;
        case (code)
            2'b00:   d = 16'(DIV_2400);
            2'b01:   d = 16'(DIV_4800);
            2'b10:   d = 16'(DIV_9600);
            default: d = 16'(DIV_19200);
        endcase
        return d;
    endfunction

    assign bit_end  = (cnt_q == div_q - 16'd1);
    assign tx_ready = (state == IDLE);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_next   = state;
        div_next     = div_q;
        cnt_next     = cnt_q;
        idx_next     = idx_q;
        shift_next   = shift_q;
        par_en_next  = par_en_q;
        par_bit_next = par_bit_q;
        tx_next      = tx;
        busy_next    = tx_busy;
        done_next    = 1'b0;

        // Bit-period timer: runs 0..DIV-1 while a frame is in flight.
        if (state != IDLE) begin
            cnt_next = bit_end ? 16'd0 : cnt_q + 16'd1;
        end

        case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_next   = START;
                    div_next     = baud_div(baud_rate);
                    cnt_next     = 16'd0;
                    shift_next   = tx_data;
                    par_en_next  = parity_en;
                    par_bit_next = (^tx_data) ^ parity_odd;
                    tx_next      = 1'b0;
                    busy_next    = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    idx_next   = 3'd0;
                    tx_next    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == LAST_DATA) begin
                        idx_next = 3'd0;
                        if (par_en_q) begin
                            state_next = PARITY;
                            tx_next    = par_bit_q;
                        end else begin
                            state_next = STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        idx_next   = idx_q + 3'd1;
                        shift_next = shift_q >> 1;
                        tx_next    = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                    idx_next   = 3'd0;
                    tx_next    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (idx_q == LAST_STOP) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        idx_next = idx_q + 3'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            div_q     <= 16'd0;
            cnt_q     <= 16'd0;
            idx_q     <= 3'd0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state     <= state_next;
            div_q     <= div_next;
            cnt_q     <= cnt_next;
            idx_q     <= idx_next;
            shift_q   <= shift_next;
            par_en_q  <= par_en_next;
            par_bit_q <= par_bit_next;
            tx        <= tx_next;
            tx_busy   <= busy_next;
            tx_done   <= done_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_uart_tx_engine
//   Directed bench for uart_tx_engine. CLOCK_FREQ is scaled to 96 kHz so the
//   divisors become 40/20/10/5 clocks per bit for 2400/4800/9600/19200.
//   Instance u_dut1: 8 data bits, 1 stop bit. Instance u_dut2: 7 data bits,
//   2 stop bits. Expected frames are written as {stop, [parity], data, start}
//   so bit k of the vector is the k-th bit on the line.
// ---------------------------------------------------------------------------
module tb_uart_tx_engine;

    localparam int unsigned FREQ = 96_000;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [1:0] baud_rate;
    logic       parity_en, parity_odd;
    logic [7:0] tx_data1;
    logic [6:0] tx_data2;
    logic       tx_valid1, tx_valid2;
    logic       tx_ready1, tx1, tx_busy1, tx_done1;
    logic       tx_ready2, tx2, tx_busy2, tx_done2;

    logic       sel;   // 0 = observe u_dut1, 1 = observe u_dut2
    logic       m_tx, m_ready, m_busy, m_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_acc   = 0;
    int done_cnt = 0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) if (tx_done1) done_cnt <= done_cnt + 1;

    assign m_tx    = sel ? tx2       : tx1;
    assign m_ready = sel ? tx_ready2 : tx_ready1;
    assign m_busy  = sel ? tx_busy2  : tx_busy1;
    assign m_done  = sel ? tx_done2  : tx_done1;

    uart_tx_engine #(.CLOCK_FREQ(FREQ), .DATA_BITS(8), .STOP_BITS(1)) u_dut1 (
        .clock      (clock),
        .reset_n    (reset_n),
        .baud_rate  (baud_rate),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .tx_data    (tx_data1),
        .tx_valid   (tx_valid1),
        .tx_ready   (tx_ready1),
        .tx         (tx1),
        .tx_busy    (tx_busy1),
        .tx_done    (tx_done1)
    );

    uart_tx_engine #(.CLOCK_FREQ(FREQ), .DATA_BITS(7), .STOP_BITS(2)) u_dut2 (
        .clock      (clock),
        .reset_n    (reset_n),
        .baud_rate  (baud_rate),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .tx_data    (tx_data2),
        .tx_valid   (tx_valid2),
        .tx_ready   (tx_ready2),
        .tx         (tx2),
        .tx_busy    (tx_busy2),
        .tx_done    (tx_done2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Present a word to the selected DUT and complete the handshake.
    // Returns 1 ns after the accept edge, with t_acc holding that edge's index.
    task automatic send(input logic [7:0] d, input logic [1:0] b, input logic pe,
                        input logic po, input logic hold);
        int guard = 0;
        @(negedge clock);
        while (!m_ready && guard < 2000) begin
            @(negedge clock);
            guard++;
        end
        if (!m_ready) check("accept_timeout", 32'(m_ready), 32'd1);
        baud_rate  = b;
        parity_en  = pe;
        parity_odd = po;
        if (sel) begin
            tx_data2  = d[6:0];
            tx_valid2 = 1'b1;
        end else begin
            tx_data1  = d;
            tx_valid1 = 1'b1;
        end
        @(posedge clock);
        #1;
        if (!hold) begin
            tx_valid1 = 1'b0;
            tx_valid2 = 1'b0;
        end
        t_acc = cyc;
        check("accept_busy", 32'(m_busy), 32'd1);
    endtask

    // Check every bit at its first and last clock, then the end-of-frame pulse.
    // With b2b set, the next accept is expected on the very next edge.
    task automatic check_frame(input string tag, input logic [15:0] bits,
                               input int n, input int div, input logic b2b);
        for (int k = 0; k < n; k++) begin
            check({tag, "_bit_first"}, 32'(m_tx), 32'(bits[k]));
            wait_cyc(div - 1);
            check({tag, "_bit_last"}, 32'(m_tx), 32'(bits[k]));
            check({tag, "_no_early_done"}, 32'(m_done), 32'd0);
            wait_cyc(1);
        end
        check({tag, "_frame_len"}, 32'(cyc - t_acc), 32'(n * div));
        check({tag, "_done"}, 32'(m_done), 32'd1);
        check({tag, "_idle_tx"}, 32'(m_tx), 32'd1);
        check({tag, "_busy_clr"}, 32'(m_busy), 32'd0);
        check({tag, "_ready"}, 32'(m_ready), 32'd1);
        wait_cyc(1);
        if (b2b) begin
            check({tag, "_b2b_start"}, 32'(m_tx), 32'd0);
            check({tag, "_b2b_gap"}, 32'(cyc - t_acc), 32'(n * div + 1));
            t_acc = cyc;
        end else begin
            check({tag, "_done_1cyc"}, 32'(m_done), 32'd0);
            check({tag, "_tx_hi"}, 32'(m_tx), 32'd1);
        end
    endtask

    initial begin
        int dc;
        reset_n    = 1'b0;
        baud_rate  = 2'b10;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        tx_data1   = 8'h00;
        tx_data2   = 7'h00;
        tx_valid1  = 1'b0;
        tx_valid2  = 1'b0;
        sel        = 1'b0;

        #23;
        check("rst_tx",    32'(tx1),       32'd1);
        check("rst_ready", 32'(tx_ready1), 32'd1);
        check("rst_busy",  32'(tx_busy1),  32'd0);
        check("rst_done",  32'(tx_done1),  32'd0);
        check("rst_tx2",   32'(tx2),       32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        wait_cyc(2);

        // 1: 8N1 at 9600 (DIV 10), 0x55.
        send(8'h55, 2'b10, 1'b0, 1'b0, 1'b0);
        check_frame("f55", {6'd0, 1'b1, 8'h55, 1'b0}, 10, 10, 1'b0);

        // 2: 0x07 at 19200 (DIV 5) with even then odd parity.
        send(8'h07, 2'b11, 1'b1, 1'b0, 1'b0);
        check_frame("par_even", {5'd0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 5, 1'b0);
        send(8'h07, 2'b11, 1'b1, 1'b1, 1'b0);
        check_frame("par_odd", {5'd0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 5, 1'b0);

        // 3: back-to-back 0xA5 then 0x3C, tx_valid held; data swapped after accept.
        dc = done_cnt;
        send(8'hA5, 2'b10, 1'b0, 1'b0, 1'b1);
        tx_data1 = 8'h3C;
        check_frame("b2b_a5", {6'd0, 1'b1, 8'hA5, 1'b0}, 10, 10, 1'b1);
        tx_valid1 = 1'b0;
        // Start bit of the second frame is already on the line; re-enter at bit 0.
        check_frame("b2b_3c", {6'd0, 1'b1, 8'h3C, 1'b0}, 10, 10, 1'b0);
        check("b2b_two_done", 32'(done_cnt - dc), 32'd2);

        // 4: baud switched 9600 -> 2400 during data bit 3; frame keeps DIV 10.
        send(8'h96, 2'b10, 1'b0, 1'b0, 1'b0);
        fork
            check_frame("cfg_cur", {6'd0, 1'b1, 8'h96, 1'b0}, 10, 10, 1'b0);
            begin
                wait_cyc(45);
                baud_rate  = 2'b00;
                parity_en  = 1'b1;
            end
        join
        send(8'h81, 2'b00, 1'b0, 1'b0, 1'b0);
        check_frame("cfg_next", {6'd0, 1'b1, 8'h81, 1'b0}, 10, 40, 1'b0);

        // 5: asynchronous reset during data bit 4, then 0xFF.
        send(8'hC3, 2'b10, 1'b0, 1'b0, 1'b0);
        wait_cyc(53);
        dc = done_cnt;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_tx",    32'(tx1),       32'd1);
        check("arst_ready", 32'(tx_ready1), 32'd1);
        check("arst_busy",  32'(tx_busy1),  32'd0);
        wait_cyc(3);
        @(negedge clock);
        reset_n = 1'b1;
        wait_cyc(30);
        check("arst_no_done", 32'(done_cnt - dc), 32'd0);
        check("arst_idle_tx", 32'(tx1), 32'd1);
        send(8'hFF, 2'b10, 1'b0, 1'b0, 1'b0);
        check_frame("after_rst", {6'd0, 1'b1, 8'hFF, 1'b0}, 10, 10, 1'b0);

        // 6: tx_valid pulsed with 0x00 while busy must be ignored.
        dc = done_cnt;
        send(8'h5A, 2'b10, 1'b0, 1'b0, 1'b0);
        fork
            check_frame("busy_pulse", {6'd0, 1'b1, 8'h5A, 1'b0}, 10, 10, 1'b0);
            begin
                wait_cyc(30);
                tx_data1  = 8'h00;
                tx_valid1 = 1'b1;
                wait_cyc(1);
                tx_valid1 = 1'b0;
            end
        join
        wait_cyc(20);
        check("no_extra_frame_tx",   32'(tx1),      32'd1);
        check("no_extra_frame_busy", 32'(tx_busy1), 32'd0);
        check("one_done_only",       32'(done_cnt - dc), 32'd1);

        // 7N2 instance at 19200: stop level lasts 2*DIV before tx_done.
        sel = 1'b1;
        send(8'hD5, 2'b11, 1'b0, 1'b0, 1'b0);
        check_frame("sb2", {6'd0, 2'b11, 7'h55, 1'b0}, 10, 5, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
